// File: rtl/cdb_pkg.sv
// Shared widths, requester indices and the registered CDB packet type.
package cdb_pkg;

    localparam int TAG_W  = 6;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam int REQ_INT  = 0;
    localparam int REQ_LDST = 1;
    localparam int REQ_MULT = 2;
    localparam int REQ_DIV  = 3;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              wr;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr upward.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!enable || rst)
            grant = '0;
    end

    // A grant always coincides with a transfer since grant is masked by req.
    always_comb begin
        ptr_nxt = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i])
                ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant, payload mux and registered broadcast.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*REG_W-1:0]  req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_wr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [REG_W-1:0]          cdb_rd,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      write_en_regfile
);

    import cdb_pkg::*;

    logic [NUM_REQ-1:0] grant;
    cdb_pkt_t           nxt;
    cdb_pkt_t           pkt_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .enable (~flush),
        .grant  (grant)
    );

    always_comb begin
        nxt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                nxt.valid = 1'b1;
                nxt.tag   = req_tag[i*TAG_W +: TAG_W];
                nxt.rd    = req_rd[i*REG_W +: REG_W];
                nxt.data  = req_data[i*DATA_W +: DATA_W];
                nxt.wr    = req_wr[i];
            end
        end
    end

    // Payload fields hold across idle cycles; only valid is updated every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q <= '0;
        end else begin
            pkt_q.valid <= nxt.valid;
            if (nxt.valid) begin
                pkt_q.tag  <= nxt.tag;
                pkt_q.rd   <= nxt.rd;
                pkt_q.data <= nxt.data;
                pkt_q.wr   <= nxt.wr;
            end
        end
    end

    assign req_ready        = grant;
    assign cdb_valid        = pkt_q.valid;
    assign cdb_tag          = pkt_q.tag;
    assign cdb_rd           = pkt_q.rd;
    assign cdb_data         = pkt_q.data;
    assign write_en_regfile = pkt_q.valid & pkt_q.wr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, fairness, wrap, flush, store, reset mid-broadcast.
module tb_cdb_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [N-1:0]  req_valid;
    logic [N*6-1:0]  req_tag;
    logic [N*5-1:0]  req_rd;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_wr;
    logic [N-1:0]  req_ready;
    logic          cdb_valid;
    logic [5:0]    cdb_tag;
    logic [4:0]    cdb_rd;
    logic [31:0]   cdb_data;
    logic          write_en_regfile;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(6), .REG_W(5), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_tag          (req_tag),
        .req_rd           (req_rd),
        .req_data         (req_data),
        .req_wr           (req_wr),
        .req_ready        (req_ready),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_rd           (cdb_rd),
        .cdb_data         (cdb_data),
        .write_en_regfile (write_en_regfile)
    );

    always #5 clk = ~clk;

    // Requesters must keep valid asserted until granted.
    logic [N-1:0] held = '0;
    always @(negedge clk) begin
        if ((held & ~req_valid) != '0) begin
            errors <= errors + 1;
            $error("FAIL protocol_hold observed=%b required_held=%b", req_valid, held);
        end
        held <= req_valid & ~req_ready;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_cdb(input string name, input logic v, input logic [5:0] tag,
                             input logic [4:0] rd, input logic [31:0] data, input logic we);
        check({name, "_valid"}, 64'(cdb_valid), 64'(v));
        check({name, "_we"}, 64'(write_en_regfile), 64'(we));
        if (v) begin
            check({name, "_tag"}, 64'(cdb_tag), 64'(tag));
            check({name, "_rd"}, 64'(cdb_rd), 64'(rd));
            check({name, "_data"}, 64'(cdb_data), 64'(data));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [5:0] tag, input logic [4:0] rd,
                       input logic [31:0] data, input logic wr);
        req_tag[i*6 +: 6]    = tag;
        req_rd[i*5 +: 5]     = rd;
        req_data[i*32 +: 32] = data;
        req_wr[i]            = wr;
        req_valid[i]         = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        req_valid = '0; req_tag = '0; req_rd = '0; req_data = '0; req_wr = '0;
        for (int i = 0; i < N; i++)
            put(i, 6'(10 + i), 5'(1 + i), 32'h1000_0000 + 32'(i), 1'b1);

        // Reset held three cycles with all requesters valid
        for (int c = 0; c < 3; c++) begin
            tick;
            check("rst_ready", 64'(req_ready), 64'b0000);
            check_cdb("rst_cdb", 1'b0, '0, '0, '0, 1'b0);
        end
        check("rst_tag_zero", 64'(cdb_tag), 64'd0);
        check("rst_data_zero", 64'(cdb_data), 64'd0);

        // Fairness: grants 0,1,2,3 back to back
        rst = 1'b0; #1;
        check("rr_g0", 64'(req_ready), 64'b0001);
        for (int i = 0; i < N; i++) begin
            tick;
            check_cdb("rr_cdb", 1'b1, 6'(10 + i), 5'(1 + i), 32'h1000_0000 + 32'(i), 1'b1);
            req_valid[i] = 1'b0; #1;
            if (i < N - 1)
                check("rr_next", 64'(req_ready), 64'(4'b0001 << (i + 1)));
            else
                check("rr_done", 64'(req_ready), 64'b0000);
        end
        tick;
        check_cdb("rr_idle", 1'b0, '0, '0, '0, 1'b0);

        // Single request on the multiplier (ptr=0)
        put(2, 6'd5, 5'd3, 32'hDEAD_BEEF, 1'b1); #1;
        check("single_ready", 64'(req_ready), 64'b0100);
        tick;
        check_cdb("single_cdb", 1'b1, 6'd5, 5'd3, 32'hDEAD_BEEF, 1'b1);
        req_valid[2] = 1'b0; #1;
        check("single_ready_off", 64'(req_ready), 64'b0000);
        tick;
        check_cdb("single_idle", 1'b0, '0, '0, '0, 1'b0);

        // Wrap: ptr=3, requesters 0 and 3
        put(0, 6'd20, 5'd7, 32'h0000_0020, 1'b1);
        put(3, 6'd23, 5'd9, 32'h0000_0023, 1'b1); #1;
        check("wrap_g3", 64'(req_ready), 64'b1000);
        tick;
        check_cdb("wrap_cdb3", 1'b1, 6'd23, 5'd9, 32'h0000_0023, 1'b1);
        req_valid[3] = 1'b0; #1;
        check("wrap_g0", 64'(req_ready), 64'b0001);
        tick;
        check_cdb("wrap_cdb0", 1'b1, 6'd20, 5'd7, 32'h0000_0020, 1'b1);
        req_valid[0] = 1'b0;

        // Flush with ldst pending while the previous packet is on the bus (ptr=1)
        put(1, 6'd31, 5'd4, 32'hCAFE_0001, 1'b1);
        flush = 1'b1; #1;
        check("flush_ready", 64'(req_ready), 64'b0000);
        check("flush_inflight", 64'(cdb_valid), 64'd1);
        tick;
        check_cdb("flush_cdb", 1'b0, '0, '0, '0, 1'b0);
        flush = 1'b0; #1;
        check("unflush_g1", 64'(req_ready), 64'b0010);
        tick;
        check_cdb("unflush_cdb", 1'b1, 6'd31, 5'd4, 32'hCAFE_0001, 1'b1);
        req_valid[1] = 1'b0;

        // Flush must not move ptr (ptr=2): 0 and 2 pending, 2 wins after flush
        put(0, 6'd40, 5'd10, 32'h4000_0000, 1'b1);
        put(2, 6'd42, 5'd12, 32'h4200_0000, 1'b1);
        flush = 1'b1; #1;
        check("flush2_ready", 64'(req_ready), 64'b0000);
        tick;
        check_cdb("flush2_cdb", 1'b0, '0, '0, '0, 1'b0);
        flush = 1'b0; #1;
        check("flush2_g2", 64'(req_ready), 64'b0100);
        tick;
        check_cdb("flush2_cdb2", 1'b1, 6'd42, 5'd12, 32'h4200_0000, 1'b1);
        req_valid[2] = 1'b0; #1;
        check("flush2_g0", 64'(req_ready), 64'b0001);
        tick;
        check_cdb("flush2_cdb0", 1'b1, 6'd40, 5'd10, 32'h4000_0000, 1'b1);
        req_valid[0] = 1'b0;

        // Store from ldst: broadcast without register write (ptr=1)
        put(1, 6'd12, 5'd0, 32'h5555_AAAA, 1'b0); #1;
        check("store_ready", 64'(req_ready), 64'b0010);
        tick;
        check_cdb("store_cdb", 1'b1, 6'd12, 5'd0, 32'h5555_AAAA, 1'b0);
        req_valid[1] = 1'b0;
        tick;
        check_cdb("store_idle", 1'b0, '0, '0, '0, 1'b0);

        // Reset mid-broadcast resets ptr (ptr=2 before)
        put(2, 6'd50, 5'd14, 32'h5000_0002, 1'b1); #1;
        check("mid_g2", 64'(req_ready), 64'b0100);
        tick;
        req_valid[2] = 1'b0;
        put(0, 6'd51, 5'd15, 32'h5000_0000, 1'b1);
        put(3, 6'd53, 5'd16, 32'h5000_0003, 1'b1);
        rst = 1'b1; #1;
        check("mid_rst_ready", 64'(req_ready), 64'b0000);
        check("mid_rst_inflight", 64'(cdb_valid), 64'd1);
        tick;
        check_cdb("mid_rst_cdb", 1'b0, '0, '0, '0, 1'b0);
        rst = 1'b0; #1;
        check("mid_post_g0", 64'(req_ready), 64'b0001);
        tick;
        check_cdb("mid_post_cdb0", 1'b1, 6'd51, 5'd15, 32'h5000_0000, 1'b1);
        req_valid[0] = 1'b0; #1;
        check("mid_post_g3", 64'(req_ready), 64'b1000);
        tick;
        check_cdb("mid_post_cdb3", 1'b1, 6'd53, 5'd16, 32'h5000_0003, 1'b1);
        req_valid[3] = 1'b0;
        tick;
        check_cdb("end_idle", 1'b0, '0, '0, '0, 1'b0);

        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
